// File: rtl/lapido_pkg.sv
// Shared core definitions: branch op codes, branch resolver FSM states, default XLEN.
package lapido_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        RESOLVED = 2'd2
    } br_state_e;

endpackage

// File: rtl/comparator.sv
// Equality comparator: c is high when a equals b.
module comparator #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             c
);

    assign c = (a == b);

endmodule

// File: rtl/branch_resolver.sv
// ID-stage BEQ/BNE resolver: operand-wait stall, one-cycle redirect/flush on taken,
// branch statistics and a sticky operand-wait watchdog.
module branch_resolver
    import lapido_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_op,
    input  logic             id_kill,
    input  logic [XLEN-1:0]  id_pc_plus4,
    input  logic [15:0]      id_imm,
    input  logic [XLEN-1:0]  rs_val,
    input  logic [XLEN-1:0]  rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    output logic             stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count,
    output logic             wd_err
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);

    br_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              wd_err_q, wd_err_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  br_count_q, br_count_d;
    logic [CNT_W-1:0]  taken_count_q, taken_count_d;

    logic            eq;
    logic            is_branch;
    logic            shadow;
    logic            present;
    logic            ready;
    logic            taken;
    logic            resolve;
    logic [XLEN-1:0] target;

    comparator #(
        .WIDTH (XLEN)
    ) u_comparator (
        .a (rs_val),
        .b (rt_val),
        .c (eq)
    );

    // A registered taken redirect means the instruction now in ID is wrong-path.
    assign shadow    = redirect_valid_q;
    assign is_branch = (id_op == BR_BEQ) || (id_op == BR_BNE);
    assign present   = id_valid & is_branch & ~id_kill & ~shadow;
    assign ready     = rs_ready & rt_ready;
    assign taken     = (id_op == BR_BEQ) ? eq : ~eq;
    assign target    = id_pc_plus4 + {{(XLEN-18){id_imm[15]}}, id_imm, 2'b00};

    // Gated by reset so stall reads low while reset is held.
    assign stall = rst_n & present & ~ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        resolve    = 1'b0;
        unique case (state_q)
            IDLE, RESOLVED: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
                if (present && ready) begin
                    state_d = RESOLVED;
                    resolve = 1'b1;
                end else if (present) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            WAIT: begin
                if (!present) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (ready) begin
                    state_d    = RESOLVED;
                    wait_cnt_d = '0;
                    resolve    = 1'b1;
                end else if (wait_cnt_q != WAIT_SAT) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase

        wd_err_d         = wd_err_q | (wait_cnt_d == WAIT_SAT);
        redirect_valid_d = resolve & taken;
        redirect_pc_d    = (resolve & taken) ? target : '0;
        br_count_d       = br_count_q + CNT_W'(resolve);
        taken_count_d    = taken_count_q + CNT_W'(resolve & taken);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            wait_cnt_q       <= '0;
            wd_err_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            taken_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            wd_err_q         <= wd_err_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign flush_ifid     = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign taken_count    = taken_count_q;
    assign wd_err         = wd_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: scoreboard of expected resolutions checked on negedge.
module tb_branch_resolver;
    import lapido_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [1:0]  id_op;
    logic        id_kill;
    logic [31:0] id_pc_plus4;
    logic [15:0] id_imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_ready;
    logic        rt_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_ifid;
    logic [15:0] br_count;
    logic [15:0] taken_count;
    logic        wd_err;

    typedef struct {
        int          due;
        logic        taken;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [15:0] m_br = '0;
    logic [15:0] m_taken = '0;

    branch_resolver #(
        .XLEN     (32),
        .CNT_W    (16),
        .MAX_WAIT (15)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_op          (id_op),
        .id_kill        (id_kill),
        .id_pc_plus4    (id_pc_plus4),
        .id_imm         (id_imm),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .rs_ready       (rs_ready),
        .rt_ready       (rt_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .br_count       (br_count),
        .taken_count    (taken_count),
        .wd_err         (wd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        id_valid    = 1'b0;
        id_op       = BR_NONE;
        id_kill     = 1'b0;
        id_pc_plus4 = '0;
        id_imm      = '0;
        rs_val      = '0;
        rt_val      = '0;
        rs_ready    = 1'b1;
        rt_ready    = 1'b1;
    endtask

    task automatic set_br(input logic [1:0] op, input logic [31:0] pc4, input logic [15:0] imm,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic rsr, input logic rtr);
        id_valid    = 1'b1;
        id_op       = op;
        id_kill     = 1'b0;
        id_pc_plus4 = pc4;
        id_imm      = imm;
        rs_val      = rs;
        rt_val      = rt;
        rs_ready    = rsr;
        rt_ready    = rtr;
    endtask

    // Resolution driven this cycle shows up after the next rising edge.
    task automatic push(input logic tk, input logic [31:0] pc);
        q.push_back('{due: cyc + 1, taken: tk, pc: pc});
    endtask

    task automatic step(input logic exp_stall, input string tag);
        @(negedge clk);
        check(tag, {63'd0, stall}, {63'd0, exp_stall});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                m_br++;
                if (mon_e.taken) m_taken++;
                check("redirect_valid", {63'd0, redirect_valid}, {63'd0, mon_e.taken});
                check("flush_ifid", {63'd0, flush_ifid}, {63'd0, mon_e.taken});
                check("redirect_pc", {32'd0, redirect_pc}, {32'd0, mon_e.taken ? mon_e.pc : 32'd0});
            end else begin
                check("no_redirect", {63'd0, redirect_valid}, 64'd0);
                check("no_flush", {63'd0, flush_ifid}, 64'd0);
            end
            check("br_count", {48'd0, br_count}, {48'd0, m_br});
            check("taken_count", {48'd0, taken_count}, {48'd0, m_taken});
        end
    end

    initial begin
        idle_in();
        rst_n = 1'b0;
        #12;
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_rv", {63'd0, redirect_valid}, 64'd0);
        check("rst_pc", {32'd0, redirect_pc}, 64'd0);
        check("rst_flush", {63'd0, flush_ifid}, 64'd0);
        check("rst_br", {48'd0, br_count}, 64'd0);
        check("rst_taken", {48'd0, taken_count}, 64'd0);
        check("rst_wd", {63'd0, wd_err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Taken BEQ, immediately ready
        set_br(BR_BEQ, 32'h100, 16'h0004, 32'h1234, 32'h1234, 1'b1, 1'b1);
        push(1'b1, 32'h110);
        step(1'b0, "t1_stall");
        idle_in();
        step(1'b0, "t1_idle");

        // Not-taken BNE
        set_br(BR_BNE, 32'h300, 16'h0008, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1);
        push(1'b0, 32'h0);
        step(1'b0, "t2_stall");
        idle_in();
        step(1'b0, "t2_idle");

        // Operand wait of 3 cycles, negative offset
        set_br(BR_BEQ, 32'h200, 16'hFFFF, 32'h55, 32'h55, 1'b1, 1'b0);
        repeat (3) step(1'b1, "t3_wait_stall");
        rt_ready = 1'b1;
        push(1'b1, 32'h1FC);
        step(1'b0, "t3_ready_stall");
        idle_in();
        step(1'b0, "t3_idle");

        // Taken branch shadows the next ID branch (ready and not ready variants)
        for (int v = 0; v < 2; v++) begin
            set_br(BR_BEQ, 32'h400, 16'h0010, 32'h7, 32'h7, 1'b1, 1'b1);
            push(1'b1, 32'h440);
            step(1'b0, "t4_first_stall");
            set_br(BR_BEQ, 32'h800, 16'h0002, 32'h9, 32'h9, 1'b1, v[0]);
            step(1'b0, "t4_shadow_stall");
            idle_in();
            step(1'b0, "t4_idle");
        end

        // Not-taken BEQ then taken BNE back to back
        set_br(BR_BEQ, 32'h500, 16'h0001, 32'h1, 32'h2, 1'b1, 1'b1);
        push(1'b0, 32'h0);
        step(1'b0, "t5_first_stall");
        set_br(BR_BNE, 32'h600, 16'hFFFE, 32'h1, 32'h2, 1'b1, 1'b1);
        push(1'b1, 32'h5F8);
        step(1'b0, "t5_second_stall");
        idle_in();
        step(1'b0, "t5_idle");

        // Watchdog: sets after 16 not-ready cycles, not after 15
        check("wd_pre", {63'd0, wd_err}, 64'd0);
        set_br(BR_BNE, 32'h700, 16'h0003, 32'h1, 32'h1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("wd_boundary", {63'd0, wd_err}, 64'd0);
            step(1'b1, "t6_stall");
        end
        check("wd_set", {63'd0, wd_err}, 64'd1);
        repeat (2) step(1'b1, "t6_sat_stall");
        check("wd_hold", {63'd0, wd_err}, 64'd1);

        // Kill in WAIT with operands becoming ready the same cycle: kill wins
        rs_ready = 1'b1;
        id_kill  = 1'b1;
        step(1'b0, "t7_kill_stall");
        idle_in();
        step(1'b0, "t7_idle");
        set_br(BR_BEQ, 32'h900, 16'h0000, 32'h3, 32'h3, 1'b1, 1'b1);
        push(1'b1, 32'h900);
        step(1'b0, "t7_after_stall");
        idle_in();
        step(1'b0, "t7_after_idle");
        check("wd_sticky", {63'd0, wd_err}, 64'd1);

        // Target wrap-around
        set_br(BR_BEQ, 32'hFFFFFFFC, 16'h0001, 32'h8, 32'h8, 1'b1, 1'b1);
        push(1'b1, 32'h0);
        step(1'b0, "t7_wrap_stall");
        idle_in();
        step(1'b0, "t7_wrap_idle");

        // Async reset while RESOLVED
        set_br(BR_BEQ, 32'hA00, 16'h0001, 32'h4, 32'h4, 1'b1, 1'b1);
        step(1'b0, "t8_res_stall");
        mon_en = 1'b0;
        check("t8_rv_pre", {63'd0, redirect_valid}, 64'd1);
        check("t8_pc_pre", {32'd0, redirect_pc}, 64'hA04);
        rst_n = 1'b0;
        #1;
        check("t8_rv_rst", {63'd0, redirect_valid}, 64'd0);
        check("t8_pc_rst", {32'd0, redirect_pc}, 64'd0);
        check("t8_flush_rst", {63'd0, flush_ifid}, 64'd0);
        check("t8_br_rst", {48'd0, br_count}, 64'd0);
        check("t8_taken_rst", {48'd0, taken_count}, 64'd0);
        check("t8_wd_rst", {63'd0, wd_err}, 64'd0);
        idle_in();
        #2;
        rst_n = 1'b1;
        m_br    = '0;
        m_taken = '0;
        q.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Async reset while WAIT drops the pending branch
        set_br(BR_BEQ, 32'hB00, 16'h0005, 32'h6, 32'h6, 1'b0, 1'b0);
        repeat (3) step(1'b1, "t9_wait_stall");
        rst_n = 1'b0;
        #1;
        check("t9_stall_rst", {63'd0, stall}, 64'd0);
        check("t9_rv_rst", {63'd0, redirect_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("t9_stall_hold", {63'd0, stall}, 64'd0);
        idle_in();
        rst_n = 1'b1;
        repeat (3) step(1'b0, "t9_post_stall");

        // Large negative offset after reset
        set_br(BR_BNE, 32'hC00, 16'h8000, 32'h1, 32'h0, 1'b1, 1'b1);
        push(1'b1, 32'hFFFE0C00);
        step(1'b0, "t10_stall");
        idle_in();
        step(1'b0, "t10_idle");

        for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, "drain_stall");
        check("sb_drain", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves BEQ/BNE in the ID stage of the core. It takes forwarded register operands, stalls ID until both operands are valid, and compares them with the existing `comparator` equality block. On a taken branch it issues a one-cycle PC redirect and an IF/ID flush. It also keeps branch/taken statistics counters and a stall watchdog error flag for debug.

## Interface
- XLEN, 32, operand and PC width
- CNT_W, 16, width of statistics counters
- MAX_WAIT, 15, operand-wait cycles tolerated before `wd_err` sets
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_op  in  2  branch kind: 0 none, 1 BEQ, 2 BNE, 3 reserved (treated as none)
- id_kill  in  1  abort current ID instruction (older exception); highest priority
- id_pc_plus4  in  XLEN  PC of branch + 4
- id_imm  in  16  raw branch offset, in words
- rs_val, rt_val  in  XLEN  forwarded operands
- rs_ready, rt_ready  in  1  operand valid this cycle
- stall  out  1  hold PC and IF/ID (combinational)
- redirect_valid  out  1  one-cycle pulse, taken branch
- redirect_pc  out  XLEN  target, valid with `redirect_valid`
- flush_ifid  out  1  equal to `redirect_valid`
- br_count, taken_count  out  CNT_W  resolved branches / taken branches
- wd_err  out  1  sticky watchdog error

## Operation
- Branch present = `id_valid & (id_op==1 | id_op==2) & !id_kill & !shadow`.
  - `shadow` is high in the RESOLVED cycle after a taken branch, because the ID instruction then is wrong-path.
- Operands ready = `rs_ready & rt_ready`. `eq` comes from the `comparator` instance. taken = BEQ ? eq : !eq.
- Target = `id_pc_plus4 + (sext(id_imm) << 2)`, modulo 2^XLEN, wrap-around silently.
- FSM states:
  - IDLE: branch present and ready → RESOLVED. Branch present and not ready → WAIT with wait_cnt=1.
  - WAIT: `id_kill` → IDLE. Ready → RESOLVED. Else wait_cnt++ saturating at MAX_WAIT+1. When wait_cnt reaches MAX_WAIT+1, `wd_err` sets and stays set until reset. The state stays WAIT.
  - RESOLVED: one cycle, outputs registered. If a new non-shadow branch is present it is evaluated exactly as from IDLE. Otherwise → IDLE.
- `stall = branch present & !ready`, driven in both IDLE and WAIT. Upstream holds ID inputs stable while `stall`=1.
- On entry to RESOLVED:
  - br_count++.
  - taken_count++ if taken.
  - redirect_valid/flush_ifid = taken; redirect_pc = target if taken, else 0.
- Counters wrap at 2^CNT_W.
- `id_kill` same cycle as ready: kill wins. No redirect, no count, → IDLE.
- Reserved op or `id_valid`=0: no stall, no effect.

## Timing
- Reset values: IDLE, stall=0, redirect_valid=0, redirect_pc=0, flush_ifid=0, counters=0, wd_err=0, wait_cnt=0.
- Latency: branch ready in cycle T → redirect in T+1. Branch waiting k cycles → redirect in T+k+1, with `stall` high for cycles T..T+k-1.
- Back-to-back branches, first not taken: second resolves one cycle later.
- Back-to-back branches, first taken: second is shadowed and ignored.
- Reset mid-WAIT or mid-RESOLVED: all outputs return to reset values asynchronously, and the pending branch is dropped.

## Structure
- Shared package `lapido_pkg`:
  - branch op codes BR_NONE/BR_BEQ/BR_BNE.
  - FSM state encoding IDLE/WAIT/RESOLVED.
  - XLEN default.
- Sub-module: `comparator` (existing 32-bit equality block, ports a, b, c), instantiated once on rs_val/rt_val.
- Target adder and counters are inline.

## Test plan
- Reset, then BEQ with rs=rt=0x1234, ready, pc+4=0x100, imm=0x0004 → cycle+1: redirect_valid=1, redirect_pc=0x110, flush_ifid=1, br_count=1, taken_count=1.
- BNE with rs=rt=0xDEADBEEF, ready → no redirect, stall=0, br_count=1, taken_count=0.
- BEQ with equal operands, imm=0xFFFF, pc+4=0x200, rt_ready low for 3 cycles → stall high 3 cycles, then redirect_pc=0x1FC one cycle later.
- Taken BEQ followed immediately by a BEQ in ID during RESOLVED → second ignored, br_count=1.
- Not-taken BEQ followed by a taken BNE (rs=1, rt=2) → two resolutions in consecutive cycles, br_count=2, taken_count=1.
- Operands not ready for 16 cycles → wd_err=1 and stays 1.
- Same setup with id_kill pulsed in WAIT → IDLE, no count change.
- rst_n low mid-wait → all outputs 0 immediately.
